// File: rtl/mdl_alignp_transmit.sv
// Serialises a 40-bit primitive word (four 10-bit characters) onto a differential pair.
// Optional word counter output o_word_cnt is enabled by defining MDL_ALIGNP_TX_WORD_COUNT_EN.
module mdl_alignp_transmit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        burst_en,
    input  logic [39:0] data_p,
    output logic        tx_p,
    output logic        tx_n,
    output logic        o_word_start,
`ifdef MDL_ALIGNP_TX_WORD_COUNT_EN
    output logic [5:0]  o_bit_idx,
    output logic [15:0] o_word_cnt
`else
    output logic [5:0]  o_bit_idx
`endif
);

    // Bit counter split into character (0..3) and position within character (0..9);
    // together they name the next bit to drive.
    logic [1:0]  char_q;
    logic [3:0]  pos_q;
    logic [39:0] word_q;

    logic        at_start;
    logic [39:0] cur_word;
    logic [9:0]  cur_char;
    logic        cur_bit;
    logic [5:0]  cur_idx;

    assign at_start = (char_q == 2'd0) && (pos_q == 4'd0);

    // At a word boundary the fresh data_p is driven directly so bit 0 appears one edge later.
    assign cur_word = at_start ? data_p : word_q;

    always_comb begin
        cur_char = cur_word[9:0];
        unique case (char_q)
            2'd0: cur_char = cur_word[9:0];
            2'd1: cur_char = cur_word[19:10];
            2'd2: cur_char = cur_word[29:20];
            2'd3: cur_char = cur_word[39:30];
            default: cur_char = cur_word[9:0];
        endcase
    end

    // Each character goes out MSB first.
    assign cur_bit = cur_char[4'd9 - pos_q];
    assign cur_idx = {4'd0, char_q} * 6'd10 + {2'd0, pos_q};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            char_q       <= 2'd0;
            pos_q        <= 4'd0;
            word_q       <= 40'd0;
            tx_p         <= 1'b0;
            tx_n         <= 1'b0;
            o_word_start <= 1'b0;
            o_bit_idx    <= 6'd0;
        end else if (!burst_en) begin
            char_q       <= 2'd0;
            pos_q        <= 4'd0;
            tx_p         <= 1'b0;
            tx_n         <= 1'b0;
            o_word_start <= 1'b0;
            o_bit_idx    <= 6'd0;
        end else begin
            if (at_start) begin
                word_q <= data_p;
            end
            tx_p         <= cur_bit;
            tx_n         <= ~cur_bit;
            o_word_start <= at_start;
            o_bit_idx    <= cur_idx;
            if (pos_q == 4'd9) begin
                pos_q  <= 4'd0;
                char_q <= char_q + 2'd1;
            end else begin
                pos_q <= pos_q + 4'd1;
            end
        end
    end

`ifdef MDL_ALIGNP_TX_WORD_COUNT_EN
    // Counts latched words; holds through idle, wraps naturally at 16 bits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_word_cnt <= 16'd0;
        end else if (burst_en && at_start) begin
            o_word_cnt <= o_word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mdl_alignp_transmit.sv
// Self-checking bench for mdl_alignp_transmit: directed scenarios plus randomized traffic
// compared against a word/position reference model.
module tb_mdl_alignp_transmit;

    logic        clk = 1'b0;
    logic        rst;
    logic        burst_en;
    logic [39:0] data_p;
    logic        tx_p;
    logic        tx_n;
    logic        word_start;
    logic [5:0]  bit_idx;
`ifdef MDL_ALIGNP_TX_WORD_COUNT_EN
    logic [15:0] word_cnt;
`endif

    mdl_alignp_transmit dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .burst_en     (burst_en),
        .data_p       (data_p),
        .tx_p         (tx_p),
        .tx_n         (tx_n),
        .o_word_start (word_start),
`ifdef MDL_ALIGNP_TX_WORD_COUNT_EN
        .o_bit_idx    (bit_idx),
        .o_word_cnt   (word_cnt)
`else
        .o_bit_idx    (bit_idx)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [39:0] ALIGN_P   = 40'b0010011100_0101010101_0101010101_0011111010;
    localparam logic [39:0] SYNC_P    = 40'b1010101010_1010101010_1010100010_0011110011;
    // Expected serial stream, first transmitted bit in the MSB.
    localparam logic [39:0] ALIGN_SEQ = 40'b0011111010_0101010101_0101010101_0010011100;
    localparam logic [9:0]  SYNC_HEAD = 10'b0011110011;

    int checks   = 0;
    int failures = 0;

    // Reference model: latched word, next position, expected outputs.
    logic [39:0] m_word;
    int          m_pos;
    logic        e_tx;
    logic        e_ws;
    int          e_idx;
    int          m_cnt;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [39:0] d);
        @(negedge clk);
        rst      = r;
        burst_en = en;
        data_p   = d;
        @(posedge clk);
        if (r) begin
            m_pos = 0; m_word = '0; e_tx = 1'b0; e_ws = 1'b0; e_idx = 0; m_cnt = 0;
        end else if (!en) begin
            m_pos = 0; e_tx = 1'b0; e_ws = 1'b0; e_idx = 0;
        end else begin
            e_ws = (m_pos == 0);
            if (e_ws) begin
                m_word = d;
                m_cnt  = (m_cnt + 1) % 65536;
            end
            e_idx = m_pos;
            e_tx  = m_word[10 * (m_pos / 10) + 9 - (m_pos % 10)];
            m_pos = (m_pos + 1) % 40;
        end
        #1;
        check("tx_p", {15'd0, tx_p}, {15'd0, e_tx});
        check("tx_n", {15'd0, tx_n}, {15'd0, (r || !en) ? 1'b0 : ~e_tx});
        check("word_start", {15'd0, word_start}, {15'd0, e_ws});
        check("bit_idx", {10'd0, bit_idx}, 16'(e_idx));
`ifdef MDL_ALIGNP_TX_WORD_COUNT_EN
        check("word_cnt", word_cnt, 16'(m_cnt));
`endif
    endtask

    initial begin
        logic [39:0] seq;
        logic [9:0]  head;
        logic [63:0] rnd;
        int          pulses;

        rst = 1'b1; burst_en = 1'b0; data_p = '0;
        m_word = '0; m_pos = 0; e_tx = 0; e_ws = 0; e_idx = 0; m_cnt = 0;
        seq  = ALIGN_SEQ;
        head = SYNC_HEAD;

        // Reset state, with burst_en high to show reset priority.
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, ALIGN_P);
        check("rst_tx_p", {15'd0, tx_p}, 16'd0);
        check("rst_idx", {10'd0, bit_idx}, 16'd0);

        // Continuous ALIGN: literal stream, repeating every 40 bits.
        for (int k = 0; k < 80; k++) begin
            step(1'b0, 1'b1, ALIGN_P);
            check("align_stream", {15'd0, tx_p}, {15'd0, seq[39 - (k % 40)]});
            check("align_diff", {15'd0, tx_n}, {15'd0, ~seq[39 - (k % 40)]});
        end

        // 160 on / 480 off, twice.
        step(1'b0, 1'b0, ALIGN_P);
        for (int b = 0; b < 2; b++) begin
            pulses = 0;
            for (int k = 0; k < 160; k++) begin
                step(1'b0, 1'b1, ALIGN_P);
                pulses += int'(word_start);
                if (k % 40 == 0) check("start_at_bit0", {15'd0, word_start}, 16'd1);
            end
            check("words_per_burst", 16'(pulses), 16'd4);
            for (int k = 0; k < 480; k++) begin
                step(1'b0, 1'b0, ALIGN_P);
                if (k % 97 == 0) begin
                    check("gap_tx_p", {15'd0, tx_p}, 16'd0);
                    check("gap_tx_n", {15'd0, tx_n}, 16'd0);
                end
            end
        end

        // SYNC presented mid-word: ALIGN word completes, next word is SYNC.
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, ALIGN_P);
        for (int k = 20; k < 40; k++) begin
            step(1'b0, 1'b1, SYNC_P);
            check("align_unchanged", {15'd0, tx_p}, {15'd0, seq[39 - k]});
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, SYNC_P);
            check("sync_head", {15'd0, tx_p}, {15'd0, head[9 - k]});
        end
        for (int k = 10; k < 40; k++) step(1'b0, 1'b1, SYNC_P);

        // Abort at bit 17, idle 5 cycles, restart with fresh data.
        for (int k = 0; k < 17; k++) step(1'b0, 1'b1, ALIGN_P);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, ALIGN_P);
            check("abort_idle", {14'd0, tx_p, tx_n}, 16'd0);
        end
        step(1'b0, 1'b1, SYNC_P);
        check("abort_restart_idx", {10'd0, bit_idx}, 16'd0);
        check("abort_restart_bit", {15'd0, tx_p}, {15'd0, head[9]});
        for (int k = 1; k < 40; k++) step(1'b0, 1'b1, SYNC_P);

        // Reset at bit 30.
        for (int k = 0; k < 30; k++) step(1'b0, 1'b1, ALIGN_P);
        step(1'b1, 1'b1, ALIGN_P);
        check("rst_mid_tx", {14'd0, tx_p, tx_n}, 16'd0);
        check("rst_mid_idx", {10'd0, bit_idx}, 16'd0);
        step(1'b0, 1'b1, ALIGN_P);
        check("post_rst_start", {15'd0, word_start}, 16'd1);
        check("post_rst_idx", {10'd0, bit_idx}, 16'd0);
        for (int k = 1; k < 40; k++) step(1'b0, 1'b1, ALIGN_P);

`ifdef MDL_ALIGNP_TX_WORD_COUNT_EN
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 4000; k++) step(1'b0, 1'b1, ALIGN_P);
        check("cnt_100", word_cnt, 16'd100);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, ALIGN_P);
        check("cnt_hold", word_cnt, 16'd100);
        step(1'b1, 1'b0, ALIGN_P);
        check("cnt_clear", word_cnt, 16'd0);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rnd = {$urandom, $urandom};
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) != 0, rnd[39:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
